traffic_phase_scheduler: RTL and testbench
==========================================

Name: traffic_phase_scheduler

Overview:
- Sequential controller that shares the intersection between the EW and NS approaches.
- Latches car-sensor requests and sequences each direction through green, yellow and all-red.
- Green time is bounded by minimum and maximum hold times.
- Replaces the combinational light decode in the traffic-light subsystem; sensors feed in directly and the light outputs drive the lamp drivers.

Parameters:
MIN_GREEN, 8, minimum green cycles before a gap-out switch is allowed (>=1)
MAX_GREEN, 24, green cycles after which the light switches even if the own car is present (>=MIN_GREEN)
YELLOW, 3, yellow duration in cycles (>=1)
ALL_RED, 2, all-red clearance in cycles (>=1)
CNT_W, 5, phase timer width; must hold MAX_GREEN-1

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  synchronous, active-low reset
ew_car  in  1  EW sensor, level, synchronous to clk
ns_car  in  1  NS sensor, level, synchronous to clk
ew_light  out  2  EW lamp: RED=0, GREEN=1, YELLOW=2
ns_light  out  2  NS lamp, same encoding
ew_pending  out  1  latched EW service request
ns_pending  out  1  latched NS service request
phase  out  3  current state encoding, for debug and bench

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_n), sampled on rising clk.
- Reset state (rst_n=0 at an edge): phase=ALL_RED_TO_NS, timer=0, both pendings 0, both lights RED.
- Reset overrides everything, including mid-green or mid-yellow.
- States: ALL_RED_TO_NS, NS_GREEN, NS_YELLOW, ALL_RED_TO_EW, EW_GREEN, EW_YELLOW.
- Lights: Moore decode of the state register; no extra latency.
  - Yellow and all-red states show RED on the non-owning direction.
  - All-red states show RED on both directions.
- Timer:
  - Clears to 0 on every state change; otherwise increments.
  - Saturates at MAX_GREEN-1 in green states.
- ALL_RED_TO_X -> X_GREEN when timer==ALL_RED-1.
- X_YELLOW -> ALL_RED_TO_(other) when timer==YELLOW-1.
- X_GREEN -> X_YELLOW only if other_pending=1, and either:
  - gap-out: timer>=MIN_GREEN-1 and own car=0, or
  - max-out: timer>=MAX_GREEN-1.
- With no opposing request, green holds indefinitely (rest in green).
- Pending flags:
  - ew_pending sets on any cycle with ew_car=1 while state!=EW_GREEN, including EW_YELLOW and all-red.
  - ew_pending clears on the edge entering EW_GREEN; clear wins over a simultaneous set.
  - NS is symmetric.
- A car present during its own green does not set its pending flag.
- Both requests pending simultaneously: the current owner finishes its green; strict alternation follows, with no starvation.
- Illegal phase encodings recover to ALL_RED_TO_NS on the next edge.

Decomposition:
- traffic_pkg holds:
  - light encoding constants RED/GREEN/YELLOW
  - phase state enum (3-bit)
  - default timing constants
- Sub-module phase_timer: CNT_W counter with clear, increment and saturate-at-limit inputs.
- Pending latches and FSM stay in the top module.

Test Plan:
- Reset: rst_n=0 for 3 cycles then 1 -> lights RED/RED, phase=ALL_RED_TO_NS for 2 cycles, then ns_light=GREEN on the 3rd cycle after release.
- Rest in green: no cars for 100 cycles -> ns_light stays GREEN, timer saturates at 23, ew_light stays RED.
- Gap-out: 1-cycle ew_car pulse at NS timer=2, ns_car=0 -> ew_pending=1 next cycle.
  - NS_GREEN holds through timer=7, then YELLOW for 3 cycles, all-red for 2, then EW GREEN.
  - ew_pending=0 in the first EW_GREEN cycle.
- Max-out: ns_car=1 and ew_car=1 held -> each green lasts exactly 24 cycles, then 3 yellow and 2 all-red.
  - Sequence NS, EW, NS repeats with a period of 58 cycles.
- Late request: ew_car pulse during EW_YELLOW -> ew_pending=1.
  - EW is re-served after the next NS green: 8 cycles with ns_car=0, plus 3 yellow and 2 all-red.
- Reset mid-operation: rst_n=0 for 1 cycle during EW_GREEN with ns_pending=1 -> next cycle RED/RED, both pendings 0, phase=ALL_RED_TO_NS.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared light encodings, phase states and default timing for the intersection controller.
package traffic_pkg;

  localparam logic [1:0] RED    = 2'd0;
  localparam logic [1:0] GREEN  = 2'd1;
  localparam logic [1:0] YELLOW = 2'd2;

  localparam int unsigned DEF_MIN_GREEN = 8;
  localparam int unsigned DEF_MAX_GREEN = 24;
  localparam int unsigned DEF_YELLOW    = 3;
  localparam int unsigned DEF_ALL_RED   = 2;
  localparam int unsigned DEF_CNT_W     = 5;

  typedef enum logic [2:0] {
    ALL_RED_TO_NS = 3'd0,
    NS_GREEN      = 3'd1,
    NS_YELLOW     = 3'd2,
    ALL_RED_TO_EW = 3'd3,
    EW_GREEN      = 3'd4,
    EW_YELLOW     = 3'd5
  } phase_t;

  // EW lamp for a given phase; everything not owned by EW is red.
  function automatic logic [1:0] ew_lamp(input phase_t p);
    case (p)
      EW_GREEN:  return GREEN;
      EW_YELLOW: return YELLOW;
      default:   return RED;
    endcase
  endfunction

  // NS lamp for a given phase; everything not owned by NS is red.
  function automatic logic [1:0] ns_lamp(input phase_t p);
    case (p)
      NS_GREEN:  return GREEN;
      NS_YELLOW: return YELLOW;
      default:   return RED;
    endcase
  endfunction

endpackage

// File: rtl/traffic_phase_scheduler_phase_timer.sv
// Phase timer: clears on request, otherwise counts up, optionally holding at a limit.
module phase_timer #(
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  input  logic             sat,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] count
);

  // Counter register with clear priority over increment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !(sat && (count >= limit))) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Two-approach intersection controller: latches sensor requests and sequences
// green / yellow / all-red with min/max green hold and rest-in-green.
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int unsigned MIN_GREEN = DEF_MIN_GREEN,
  parameter int unsigned MAX_GREEN = DEF_MAX_GREEN,
  parameter int unsigned YELLOW    = DEF_YELLOW,
  parameter int unsigned ALL_RED   = DEF_ALL_RED,
  parameter int unsigned CNT_W     = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ew_car,
  input  logic       ns_car,
  output logic [1:0] ew_light,
  output logic [1:0] ns_light,
  output logic       ew_pending,
  output logic       ns_pending,
  output logic [2:0] phase
);

  localparam logic [CNT_W-1:0] T_MIN = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] T_MAX = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] T_YEL = CNT_W'(YELLOW - 1);
  localparam logic [CNT_W-1:0] T_RED = CNT_W'(ALL_RED - 1);

  phase_t           state_q;
  phase_t           state_d;
  logic [CNT_W-1:0] timer;
  logic             state_chg;
  logic             in_green;
  logic             ew_pend_d;
  logic             ns_pend_d;
  logic [1:0]       ew_light_d;
  logic [1:0]       ns_light_d;

  assign phase = state_q;

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_chg),
    .inc   (1'b1),
    .sat   (in_green),
    .limit (T_MAX),
    .count (timer)
  );

  // State, pending latches and lamp registers; lamps are loaded from the
  // next state so they line up with the phase register without extra latency.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ALL_RED_TO_NS;
      ew_pending <= 1'b0;
      ns_pending <= 1'b0;
      ew_light   <= RED;
      ns_light   <= RED;
    end else begin
      state_q    <= state_d;
      ew_pending <= ew_pend_d;
      ns_pending <= ns_pend_d;
      ew_light   <= ew_light_d;
      ns_light   <= ns_light_d;
    end
  end

  // Next-state, request latching and lamp decode.
  always_comb begin
    state_d   = state_q;
    ew_pend_d = ew_pending;
    ns_pend_d = ns_pending;

    case (state_q)
      ALL_RED_TO_NS: if (timer == T_RED) state_d = NS_GREEN;
      NS_GREEN:      if (ew_pending && (((timer >= T_MIN) && !ns_car) || (timer >= T_MAX)))
                       state_d = NS_YELLOW;
      NS_YELLOW:     if (timer == T_YEL) state_d = ALL_RED_TO_EW;
      ALL_RED_TO_EW: if (timer == T_RED) state_d = EW_GREEN;
      EW_GREEN:      if (ns_pending && (((timer >= T_MIN) && !ew_car) || (timer >= T_MAX)))
                       state_d = EW_YELLOW;
      EW_YELLOW:     if (timer == T_YEL) state_d = ALL_RED_TO_NS;
      default:       state_d = ALL_RED_TO_NS;
    endcase

    state_chg = (state_d != state_q);
    in_green  = (state_q == NS_GREEN) || (state_q == EW_GREEN);

    // A request is latched whenever its own green is not showing; entering
    // the green clears it and wins over a same-cycle set.
    if (ew_car && (state_q != EW_GREEN)) ew_pend_d = 1'b1;
    if ((state_d == EW_GREEN) && (state_q != EW_GREEN)) ew_pend_d = 1'b0;
    if (ns_car && (state_q != NS_GREEN)) ns_pend_d = 1'b1;
    if ((state_d == NS_GREEN) && (state_q != NS_GREEN)) ns_pend_d = 1'b0;

    ew_light_d = ew_lamp(state_d);
    ns_light_d = ns_lamp(state_d);
  end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Scoreboard bench: stimulus schedules expected per-cycle observations,
// a negedge monitor pops and checks them against the DUT.
module tb_traffic_phase_scheduler;
  import traffic_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ew_car;
  logic       ns_car;
  logic [1:0] ew_light;
  logic [1:0] ns_light;
  logic       ew_pending;
  logic       ns_pending;
  logic [2:0] phase;

  int cyc     = 0;
  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int         cyc;
    bit         chk_ph;
    logic [2:0] ph;
    bit         chk_pd;
    logic       ewp;
    logic       nsp;
    bit         chk_tm;
    logic [4:0] tm;
    string      nm;
  } exp_t;

  exp_t sb[$];

  traffic_phase_scheduler dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ew_car     (ew_car),
    .ns_car     (ns_car),
    .ew_light   (ew_light),
    .ns_light   (ns_light),
    .ew_pending (ew_pending),
    .ns_pending (ns_pending),
    .phase      (phase)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected lamps per phase number: 0 ARN, 1 NSG, 2 NSY, 3 ARE, 4 EWG, 5 EWY.
  function automatic logic [1:0] exp_ew(input logic [2:0] p);
    case (p)
      3'd4:    return 2'd1;
      3'd5:    return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [1:0] exp_ns(input logic [2:0] p);
    case (p)
      3'd1:    return 2'd1;
      3'd2:    return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  task automatic push(input int c, input bit cp, input logic [2:0] p, input bit cd,
                      input logic ew, input logic ns, input bit ct, input logic [4:0] t,
                      input string nm);
    exp_t e;
    e.cyc = c; e.chk_ph = cp; e.ph = p; e.chk_pd = cd; e.ewp = ew; e.nsp = ns;
    e.chk_tm = ct; e.tm = t; e.nm = nm;
    sb.push_back(e);
  endtask

  task automatic exp_ph(input int c, input logic [2:0] p, input string nm);
    push(c, 1'b1, p, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, nm);
  endtask

  task automatic exp_pd(input int c, input logic ew, input logic ns, input string nm);
    push(c, 1'b0, 3'd0, 1'b1, ew, ns, 1'b0, 5'd0, nm);
  endtask

  task automatic exp_tm(input int c, input logic [4:0] t, input string nm);
    push(c, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, t, nm);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int c);
    while (cyc < c) step();
  endtask

  // Monitor: compare every scheduled expectation in the cycle it targets.
  always @(negedge clk) begin
    int   i;
    exp_t e;
    i = 0;
    while (i < sb.size()) begin
      e = sb[i];
      if (e.cyc < cyc) begin
        n_tests++; n_fail++;
        $display("FAIL %s: expectation for cycle %0d never checked (now %0d)", e.nm, e.cyc, cyc);
        sb.delete(i);
      end else if (e.cyc == cyc) begin
        if (e.chk_ph) begin
          n_tests++;
          if ({ew_light, ns_light, phase} !== {exp_ew(e.ph), exp_ns(e.ph), e.ph}) begin
            n_fail++;
            $display("FAIL %s cyc=%0d: got ew=%0d ns=%0d phase=%0d, expected ew=%0d ns=%0d phase=%0d",
                     e.nm, cyc, ew_light, ns_light, phase, exp_ew(e.ph), exp_ns(e.ph), e.ph);
          end
        end
        if (e.chk_pd) begin
          n_tests++;
          if ({ew_pending, ns_pending} !== {e.ewp, e.nsp}) begin
            n_fail++;
            $display("FAIL %s cyc=%0d: got ew_pending=%0b ns_pending=%0b, expected %0b %0b",
                     e.nm, cyc, ew_pending, ns_pending, e.ewp, e.nsp);
          end
        end
        if (e.chk_tm) begin
          n_tests++;
          if (dut.u_timer.count !== e.tm) begin
            n_fail++;
            $display("FAIL %s cyc=%0d: got timer=%0d, expected %0d", e.nm, cyc, dut.u_timer.count, e.tm);
          end
        end
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  int r, g0, p, e1, g2;

  initial begin
    rst_n  = 1'b0;
    ew_car = 1'b0;
    ns_car = 1'b0;

    // Reset for 3 edges, then release.
    repeat (3) step();
    r = cyc;
    exp_ph(r, ALL_RED_TO_NS, "reset_phase");
    exp_pd(r, 1'b0, 1'b0, "reset_pending");
    exp_tm(r, 5'd0, "reset_timer");
    exp_ph(r + 1, ALL_RED_TO_NS, "reset_allred_2nd");
    exp_ph(r + 2, NS_GREEN, "reset_first_green");
    rst_n = 1'b1;

    // Rest in NS green with no cars; timer saturates.
    g0 = r + 2;
    exp_tm(g0 + 7, 5'd7, "rest_timer7");
    exp_tm(g0 + 23, 5'd23, "rest_timer_sat");
    exp_ph(g0 + 100, NS_GREEN, "rest_hold_green");
    exp_tm(g0 + 100, 5'd23, "rest_timer_hold");
    exp_pd(g0 + 100, 1'b0, 1'b0, "rest_no_pending");

    // EW pulse with saturated NS timer: immediate gap-out.
    p = g0 + 100;
    exp_pd(p + 1, 1'b1, 1'b0, "sat_ew_latched");
    exp_ph(p + 1, NS_GREEN, "sat_last_green");
    exp_ph(p + 2, NS_YELLOW, "sat_yellow");
    exp_tm(p + 2, 5'd0, "sat_yellow_timer");
    exp_ph(p + 4, NS_YELLOW, "sat_yellow_last");
    exp_ph(p + 5, ALL_RED_TO_EW, "sat_allred");
    exp_ph(p + 6, ALL_RED_TO_EW, "sat_allred_last");
    exp_ph(p + 7, EW_GREEN, "sat_ew_green");
    exp_pd(p + 7, 1'b0, 1'b0, "sat_ew_cleared");
    goto(p);
    ew_car = 1'b1;
    step();
    ew_car = 1'b0;

    // Max-out with both cars held: 58-cycle period.
    e1 = p + 7;
    exp_ph(e1 + 23, EW_GREEN, "max_ew_last_green");
    exp_ph(e1 + 24, EW_YELLOW, "max_ew_yellow");
    exp_ph(e1 + 27, ALL_RED_TO_NS, "max_allred_ns");
    exp_ph(e1 + 29, NS_GREEN, "max_ns_green");
    exp_pd(e1 + 29, 1'b1, 1'b0, "max_ns_entry_pend");
    exp_ph(e1 + 52, NS_GREEN, "max_ns_last_green");
    exp_ph(e1 + 53, NS_YELLOW, "max_ns_yellow");
    exp_ph(e1 + 58, EW_GREEN, "max_ew_period");
    exp_ph(e1 + 81, EW_GREEN, "max_ew2_last_green");
    exp_ph(e1 + 82, EW_YELLOW, "max_ew2_yellow");
    exp_pd(e1 + 82, 1'b0, 1'b1, "own_car_no_pend");
    goto(e1);
    ew_car = 1'b1;
    ns_car = 1'b1;

    // Late EW request during EW yellow: re-served after an 8-cycle NS green.
    exp_pd(e1 + 83, 1'b1, 1'b1, "late_ew_latched");
    exp_ph(e1 + 87, NS_GREEN, "late_ns_green");
    exp_pd(e1 + 87, 1'b1, 1'b0, "late_ns_cleared");
    exp_ph(e1 + 94, NS_GREEN, "late_ns_min_hold");
    exp_ph(e1 + 95, NS_YELLOW, "late_ns_yellow");
    exp_ph(e1 + 100, EW_GREEN, "late_ew_reserved");
    exp_pd(e1 + 100, 1'b0, 1'b0, "late_ew_cleared");
    goto(e1 + 82);
    ns_car = 1'b0;
    step();
    ew_car = 1'b0;

    // Reset during EW green with NS pending.
    exp_pd(e1 + 102, 1'b0, 1'b1, "mid_ns_pending");
    exp_ph(e1 + 103, EW_GREEN, "mid_green_before_rst");
    exp_ph(e1 + 104, ALL_RED_TO_NS, "mid_rst_phase");
    exp_pd(e1 + 104, 1'b0, 1'b0, "mid_rst_pending");
    exp_tm(e1 + 104, 5'd0, "mid_rst_timer");
    exp_ph(e1 + 106, NS_GREEN, "mid_rst_green");
    goto(e1 + 101);
    ns_car = 1'b1;
    step();
    ns_car = 1'b0;
    goto(e1 + 103);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;

    // Gap-out: EW pulse at NS timer 2, NS holds through timer 7.
    g2 = e1 + 106;
    exp_pd(g2 + 3, 1'b1, 1'b0, "gap_ew_latched");
    exp_ph(g2 + 7, NS_GREEN, "gap_min_green");
    exp_tm(g2 + 7, 5'd7, "gap_timer7");
    exp_ph(g2 + 8, NS_YELLOW, "gap_yellow");
    exp_ph(g2 + 10, NS_YELLOW, "gap_yellow_last");
    exp_ph(g2 + 11, ALL_RED_TO_EW, "gap_allred");
    exp_ph(g2 + 12, ALL_RED_TO_EW, "gap_allred_last");
    exp_pd(g2 + 12, 1'b1, 1'b0, "gap_pend_held");
    exp_ph(g2 + 13, EW_GREEN, "gap_ew_green");
    exp_pd(g2 + 13, 1'b0, 1'b0, "gap_ew_cleared");
    goto(g2 + 2);
    ew_car = 1'b1;
    step();
    ew_car = 1'b0;

    goto(g2 + 16);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
